display_shifter: RTL and testbench

//  Serial transmitter at the far end of the display-data interface: takes the 24-bit frame
//  {sel[23:16], digit[15:8], led[7:0]} plus valid strobe from the display decoder and shifts
//  it into the external 74HC595-style chain (SER/SRCLK/RCLK). One frame per word, MSB first,

---
 rtl/clock_pkg.sv | 17 +
 rtl/display_shifter_tick_gen.sv | 34 +++
 rtl/display_shifter.sv | 127 ++++++++++++
 tb/tb_display_shifter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the display-data path: frame layout and serializer FSM states.
package clock_pkg;

  localparam int unsigned DISP_FRAME_W = 24;
  localparam int unsigned SEL_LSB      = 16;
  localparam int unsigned DIG_LSB      = 8;
  localparam int unsigned LED_LSB      = 0;

  typedef enum logic [2:0] {
    SH_IDLE,
    SH_LO,
    SH_HI,
    SH_LATCH,
    SH_LATEND
  } sh_state_t;

endpackage

// File: rtl/display_shifter_tick_gen.sv
// Free-running divider that strobes o_TICK once every DIV enabled cycles; parked at zero when idle.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic i_EN,
  output logic o_TICK
);

  localparam logic [7:0] LastCnt = 8'(DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!i_EN || (cnt_q == LastCnt)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign o_TICK = i_EN && (cnt_q == LastCnt);

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_shifter.sv
// Serializes one display frame MSB-first into a 74HC595-style chain, then pulses RCLK to latch it.
module display_shifter
  import clock_pkg::*;
#(
  parameter int unsigned DATA_W  = DISP_FRAME_W,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_VALID,
  input  logic [DATA_W-1:0] i_DATA,
  output logic              o_READY,
  output logic              o_SER,
  output logic              o_SCLK,
  output logic              o_RCLK,
  output logic              o_DONE,
  output logic              o_DROP
);

  localparam int unsigned CntW = $clog2(DATA_W);

  sh_state_t         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ser_q, ser_d;
  logic              sclk_q, sclk_d;
  logic              rclk_q, rclk_d;
  logic              done_q, done_d;
  logic              drop_q, drop_d;
  logic              tick;

  tick_gen #(
    .DIV (CLK_DIV)
  ) u_tick_gen (
    .i_CLK  (i_CLK),
    .i_RST  (i_RST),
    .i_EN   (state_q != SH_IDLE),
    .o_TICK (tick)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    ser_d   = ser_q;
    sclk_d  = sclk_q;
    rclk_d  = rclk_q;
    done_d  = 1'b0;
    drop_d  = i_VALID && (state_q != SH_IDLE);

    case (state_q)
      SH_IDLE: begin
        if (i_VALID) begin
          shreg_d = i_DATA;
          cnt_d   = CntW'(DATA_W - 1);
          ser_d   = i_DATA[DATA_W-1];
          state_d = SH_LO;
        end
      end
      SH_LO: begin
        if (tick) begin
          sclk_d  = 1'b1;
          state_d = SH_HI;
        end
      end
      SH_HI: begin
        if (tick) begin
          sclk_d = 1'b0;
          if (cnt_q == '0) begin
            ser_d   = 1'b0;
            rclk_d  = 1'b1;
            state_d = SH_LATCH;
          end else begin
            // Present the next bit on the same edge SCLK falls.
            shreg_d = shreg_q << 1;
            cnt_d   = cnt_q - 1'b1;
            ser_d   = shreg_q[DATA_W-2];
            state_d = SH_LO;
          end
        end
      end
      SH_LATCH: begin
        if (tick) begin
          rclk_d  = 1'b0;
          state_d = SH_LATEND;
        end
      end
      SH_LATEND: begin
        if (tick) begin
          done_d  = 1'b1;
          state_d = SH_IDLE;
        end
      end
      default: state_d = SH_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= SH_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      ser_q   <= 1'b0;
      sclk_q  <= 1'b0;
      rclk_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ser_q   <= ser_d;
      sclk_q  <= sclk_d;
      rclk_q  <= rclk_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign o_READY = (state_q == SH_IDLE);
  assign o_SER   = ser_q;
  assign o_SCLK  = sclk_q;
  assign o_RCLK  = rclk_q;
  assign o_DONE  = done_q;
  assign o_DROP  = drop_q;

endmodule

// File: tb/tb_display_shifter.sv
// Bench for display_shifter: two instances (CLK_DIV 4 and 1) each driving a modelled 595 chain.
module tb_display_shifter;

  localparam int unsigned D  = 24;
  localparam int unsigned CA = 4;
  localparam int unsigned CB = 1;

  logic          clk;
  logic          rst_a, valid_a, ready_a, ser_a, sclk_a, rclk_a, done_a, drop_a;
  logic          rst_b, valid_b, ready_b, ser_b, sclk_b, rclk_b, done_b, drop_b;
  logic [D-1:0]  data_a, data_b;

  display_shifter #(.DATA_W(D), .CLK_DIV(CA)) u_dut_a (
    .i_CLK(clk), .i_RST(rst_a), .i_VALID(valid_a), .i_DATA(data_a), .o_READY(ready_a),
    .o_SER(ser_a), .o_SCLK(sclk_a), .o_RCLK(rclk_a), .o_DONE(done_a), .o_DROP(drop_a)
  );

  display_shifter #(.DATA_W(D), .CLK_DIV(CB)) u_dut_b (
    .i_CLK(clk), .i_RST(rst_b), .i_VALID(valid_b), .i_DATA(data_b), .o_READY(ready_b),
    .o_SER(ser_b), .o_SCLK(sclk_b), .o_RCLK(rclk_b), .o_DONE(done_b), .o_DROP(drop_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  // Transaction model: busy countdown per instance, expected frame in flight.
  int           rem[2], acc_cyc[2], n_acc[2], n_done[2];
  logic         exp_done_m[2], exp_drop_m[2], rst_seen[2];
  logic [D-1:0] exp_frame[2];

  // 595 chain model plus timing bookkeeping.
  logic [D-1:0] ch_shift[2], ch_latch[2];
  logic         prev_sclk[2], prev_rclk[2], prev_ser[2];
  int           ser_age[2], since_rise[2], n_rise[2], n_rclk[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      rem[i] = 0; acc_cyc[i] = 0; n_acc[i] = 0; n_done[i] = 0;
      exp_done_m[i] = 1'b0; exp_drop_m[i] = 1'b0; rst_seen[i] = 1'b1; exp_frame[i] = '0;
      ch_shift[i] = '0; ch_latch[i] = '0;
      prev_sclk[i] = 1'b0; prev_rclk[i] = 1'b0; prev_ser[i] = 1'b0;
      ser_age[i] = 1000; since_rise[i] = 1000; n_rise[i] = 0; n_rclk[i] = 0;
    end
  end

  task automatic check(input int i, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL dut%0d %s: got %0h, expected %0h (t=%0t)", i, name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input logic rst, input logic valid,
                            input logic [D-1:0] data, input int c);
    exp_done_m[i] = 1'b0;
    exp_drop_m[i] = 1'b0;
    if (rst) begin
      if (rem[i] != 0) n_acc[i]--;
      rem[i]      = 0;
      rst_seen[i] = 1'b1;
    end else if (rem[i] == 0) begin
      if (valid) begin
        rem[i]       = (2 * D + 2) * c;
        exp_frame[i] = data;
        acc_cyc[i]   = cyc;
        n_acc[i]++;
        n_rise[i]    = 0;
        n_rclk[i]    = 0;
      end
    end else begin
      if (valid) exp_drop_m[i] = 1'b1;
      rem[i]--;
      if (rem[i] == 0) exp_done_m[i] = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, rst_a, valid_a, data_a, CA);
    model_step(1, rst_b, valid_b, data_b, CB);
    cyc++;
  end

  task automatic monitor(input int i, input int c, input logic ready, input logic ser,
                         input logic sclk, input logic rclk, input logic done, input logic drop);
    check(i, "ready", ready, rem[i] == 0);
    check(i, "done", done, exp_done_m[i]);
    check(i, "drop", drop, exp_drop_m[i]);
    check(i, "sclk_rclk_overlap", sclk && rclk, 0);
    since_rise[i]++;
    if (ser !== prev_ser[i]) begin
      if (!rst_seen[i]) begin
        check(i, "ser_change_sclk_low", sclk, 0);
        check(i, "ser_hold_after_rise", since_rise[i] >= c, 1);
      end
      ser_age[i] = 0;
    end else begin
      ser_age[i]++;
    end
    if (sclk && !prev_sclk[i]) begin
      check(i, "ser_setup_before_rise", ser_age[i] >= c, 1);
      ch_shift[i]   = {ch_shift[i][D-2:0], ser};
      n_rise[i]++;
      since_rise[i] = 0;
      if (n_rise[i] == 1) check(i, "first_rise_latency", cyc - acc_cyc[i], (i == 0) ? 5 : 2);
    end
    if (rclk && !prev_rclk[i]) begin
      ch_latch[i] = ch_shift[i];
      n_rclk[i]++;
    end
    if (exp_done_m[i]) begin
      check(i, "latched_frame", ch_latch[i], exp_frame[i]);
      check(i, "sclk_rises", n_rise[i], D);
      check(i, "rclk_pulses", n_rclk[i], 1);
      check(i, "done_latency", cyc - acc_cyc[i], (i == 0) ? 201 : 51);
      n_done[i]++;
    end
    prev_sclk[i] = sclk;
    prev_rclk[i] = rclk;
    prev_ser[i]  = ser;
    rst_seen[i]  = 1'b0;
  endtask

  always @(negedge clk) begin
    monitor(0, CA, ready_a, ser_a, sclk_a, rclk_a, done_a, drop_a);
    monitor(1, CB, ready_b, ser_b, sclk_b, rclk_b, done_b, drop_b);
  end

  task automatic send(input int i, input logic [D-1:0] data);
    if (i == 0) begin valid_a = 1'b1; data_a = data; end
    else        begin valid_b = 1'b1; data_b = data; end
    @(posedge clk); #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      seen = (i == 0) ? done_a : done_b;
    end
    #1;
    check(i, "done_timeout", seen, 1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0;
    data_a = '0; data_b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    check(0, "reset_ready", ready_a, 1);
    check(0, "reset_ser", ser_a, 0);
    check(0, "reset_sclk", sclk_a, 0);
    check(0, "reset_rclk", rclk_a, 0);
    check(0, "reset_done", done_a, 0);
    check(0, "reset_drop", drop_a, 0);
    repeat (2) @(posedge clk);
    #1;

    // Single frame, then back-to-back frame accepted in the DONE cycle.
    send(0, 24'h10_18_FE);
    wait_done(0, 300);
    check(0, "t1_latch", ch_latch[0], 24'h10_18_FE);
    send(0, 24'hA5_5A_3C);
    wait_done(0, 300);
    check(0, "t2_latch", ch_latch[0], 24'hA5_5A_3C);

    // Strobe mid-frame is dropped; input data churn must not leak in.
    send(0, 24'h3C_C3_81);
    repeat (49) @(posedge clk);
    #1;
    send(0, 24'hDE_AD_BE);
    data_a = 24'h55_55_55;
    wait_done(0, 300);
    check(0, "t3_latch", ch_latch[0], 24'h3C_C3_81);

    // Reset mid-frame aborts without latching.
    send(0, 24'h12_34_56);
    repeat (99) @(posedge clk);
    #1;
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    check(0, "t4_ready", ready_a, 1);
    check(0, "t4_ser", ser_a, 0);
    check(0, "t4_sclk", sclk_a, 0);
    check(0, "t4_rclk", rclk_a, 0);
    check(0, "t4_done", done_a, 0);
    repeat (250) @(posedge clk);
    #1;
    check(0, "t4_latch_kept", ch_latch[0], 24'h3C_C3_81);
    send(0, 24'h00_00_01);
    wait_done(0, 300);
    check(0, "t4_latch_new", ch_latch[0], 24'h00_00_01);

    // Fastest divider.
    send(1, 24'hFF_FF_FF);
    wait_done(1, 100);
    check(1, "t5_latch_ones", ch_latch[1], 24'hFF_FF_FF);
    send(1, 24'h00_00_00);
    wait_done(1, 100);
    check(1, "t5_latch_zeros", ch_latch[1], 24'h00_00_00);

    // Random frames, random gaps, occasional dropped strobes.
    for (int n = 0; n < 200; n++) begin
      int g;
      g = $urandom_range(0, 4);
      if (g > 0) begin
        repeat (g) @(posedge clk);
        #1;
      end
      send(0, 24'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 150)) @(posedge clk);
        #1;
        send(0, 24'($urandom));
      end
      wait_done(0, 400);
    end

    repeat (5) @(posedge clk);
    #1;
    check(0, "frames_completed", n_done[0], n_acc[0]);
    check(1, "frames_completed", n_done[1], n_acc[1]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
